// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC capture sequencer slice.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_READY   = 3'd4
    } adc_state_e;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } adc_edge_e;

    localparam logic [7:0] DEF_HI = 8'd150;
    localparam logic [7:0] DEF_LO = 8'd100;

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Host/ADC/FIFO-side signal bundle of the capture sequencer.
interface adc_capture_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cfg_valid;
    logic [7:0]       cfg_hi;
    logic [7:0]       cfg_lo;
    logic             cfg_edge;
    logic             cfg_single;
    logic             start;
    logic             ack;
    logic             stop;
    logic [7:0]       adc_data;
    logic [7:0]       buf_data;
    logic             buf_wr;
    logic             buf_rd_en;
    logic [CNT_W-1:0] frame_len;
    logic             trig_auto;
    logic [2:0]       state;

    modport master (
        output cfg_valid, cfg_hi, cfg_lo, cfg_edge, cfg_single,
        output start, ack, stop, adc_data,
        input  buf_data, buf_wr, buf_rd_en, frame_len, trig_auto, state
    );

    modport slave (
        input  cfg_valid, cfg_hi, cfg_lo, cfg_edge, cfg_single,
        input  start, ack, stop, adc_data,
        output buf_data, buf_wr, buf_rd_en, frame_len, trig_auto, state
    );
endinterface

// File: rtl/adc_hyst_trigger.sv
// Hysteresis edge detector: fire only after the opposite-side pre-condition was seen since clr.
module adc_hyst_trigger
    import adc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    input  logic       edge_sel,
    input  logic [7:0] adc_data,
    output logic       primed,
    output logic       fire
);
    logic pre;
    logic hit;
    logic seen_q;

    assign pre = (edge_sel == EDGE_FALL) ? (adc_data > hi) : (adc_data < lo);
    assign hit = (edge_sel == EDGE_FALL) ? (adc_data < lo) : (adc_data > hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else if (clr) begin
            seen_q <= 1'b0;
        end else if (pre) begin
            seen_q <= 1'b1;
        end
    end

    assign primed = seen_q;
    assign fire   = seen_q & hit;

endmodule

// File: rtl/adc_capture_sequencer.sv
// Acquisition frame sequencer: trigger qualify, gate LEN samples to the FIFO, hold for readout.
// Optional auto-trigger timeout is enabled by defining ADC_SEQ_AUTO_TRIG_EN.
//
// state   | meaning
// IDLE    | stopped; config and start accepted
// ARM     | waiting for the trigger pre-condition
// WAIT    | pre-condition seen; waiting for the fire crossing
// CAPTURE | buf_wr high, LEN samples written
// READY   | frame held for host readout until ack
module adc_capture_sequencer
    import adc_pkg::*;
#(
    parameter int LEN   = 3000,
    parameter int CNT_W = 16
`ifdef ADC_SEQ_AUTO_TRIG_EN
    , parameter int TIMEOUT = 1000000
`endif
) (
    input logic                    clk,
    input logic                    rst_n,
    adc_capture_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] ARM     = ST_ARM;
    localparam logic [2:0] WAIT    = ST_WAIT;
    localparam logic [2:0] CAPTURE = ST_CAPTURE;
    localparam logic [2:0] READY   = ST_READY;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    logic [2:0]       state, nxt;
    logic [7:0]       hi_q, lo_q;
    logic             edge_q, single_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       buf_data_q;
    logic             buf_wr_q, rd_en_q;
    logic             primed, fire, trig_clr, hunting, arm_entry, tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= DEF_HI;
            lo_q     <= DEF_LO;
            edge_q   <= EDGE_RISE;
            single_q <= 1'b1;
        end else if (state == IDLE && bus.cfg_valid) begin
            hi_q     <= bus.cfg_hi;
            lo_q     <= bus.cfg_lo;
            edge_q   <= bus.cfg_edge;
            single_q <= bus.cfg_single;
        end
    end

    assign hunting  = (state == ARM) || (state == WAIT);
    assign trig_clr = !hunting;

    adc_hyst_trigger u_trig (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (trig_clr),
        .hi       (hi_q),
        .lo       (lo_q),
        .edge_sel (edge_q),
        .adc_data (bus.adc_data),
        .primed   (primed),
        .fire     (fire)
    );

`ifdef ADC_SEQ_AUTO_TRIG_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             trig_auto_q;

    assign tmo_hit = hunting && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Counter is held at zero outside ARM/WAIT, so every arm starts a fresh timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            trig_auto_q <= 1'b0;
        end else begin
            tmo_cnt <= hunting ? tmo_cnt + 1'b1 : '0;
            if (arm_entry) begin
                trig_auto_q <= 1'b0;
            end else if (tmo_hit && nxt == CAPTURE) begin
                trig_auto_q <= 1'b1;
            end
        end
    end

    assign bus.trig_auto = trig_auto_q;
`else
    assign tmo_hit       = 1'b0;
    assign bus.trig_auto = 1'b0;
`endif

    always_comb begin
        nxt = state;
        if (bus.stop) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) nxt = ARM;
                ARM:     if (tmo_hit) nxt = CAPTURE; else if (primed) nxt = WAIT;
                WAIT:    if (fire || tmo_hit) nxt = CAPTURE;
                CAPTURE: if (cnt == LAST) nxt = READY;
                READY:   if (bus.ack) nxt = single_q ? IDLE : ARM;
                default: nxt = IDLE;
            endcase
        end
    end

    assign arm_entry = (nxt == ARM) && (state != ARM);

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            buf_data_q <= '0;
            buf_wr_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= nxt;
            buf_data_q <= bus.adc_data;
            buf_wr_q   <= (nxt == CAPTURE);
            rd_en_q    <= (nxt == READY);
            if (arm_entry) begin
                cnt <= '0;
            end else if (buf_wr_q && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.state     = state;
    assign bus.buf_data  = buf_data_q;
    assign bus.buf_wr    = buf_wr_q;
    assign bus.buf_rd_en = rd_en_q;
    assign bus.frame_len = cnt;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer (default build, LEN = 3000).
module tb_adc_capture_sequencer;
    localparam int LEN = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    adc_capture_sequencer_if #(.CNT_W(16)) bus ();

    adc_capture_sequencer #(.LEN(LEN), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.adc_data = v;
            tick();
        end
    endtask

    task automatic load_cfg(input logic [7:0] hi, input logic [7:0] lo, input logic e, input logic s);
        bus.cfg_valid = 1'b1; bus.cfg_hi = hi; bus.cfg_lo = lo;
        bus.cfg_edge = e; bus.cfg_single = s;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Drives samples until READY; reports first written sample, write count and fire-to-ready span.
    task automatic run_frame(input bit ramp, input int v0, output int first_data,
                             output int n_wr, output int span, output bit ready);
        int first_k;
        int v;
        first_k = -1; first_data = -1; n_wr = 0; span = 0; ready = 1'b0;
        for (int k = 0; k < 4000 && !ready; k++) begin
            v = ramp ? ((v0 + k > 255) ? 255 : v0 + k) : v0;
            bus.adc_data = v[7:0];
            tick();
            if (bus.buf_wr) begin
                if (first_k < 0) begin
                    first_k = k;
                    first_data = int'(bus.buf_data);
                end
                n_wr++;
            end
            if (bus.buf_rd_en) begin
                ready = 1'b1;
                span = k - first_k;
            end
        end
    endtask

    int first_data, n_wr, span;
    bit ready, wr_seen, rd_seen;

    initial begin
        bus.cfg_valid = 0; bus.cfg_hi = 0; bus.cfg_lo = 0; bus.cfg_edge = 0; bus.cfg_single = 0;
        bus.start = 0; bus.ack = 0; bus.stop = 0; bus.adc_data = 8'd77;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_buf_wr", bus.buf_wr, 0);
        chk("rst_rd_en", bus.buf_rd_en, 0);
        chk("rst_frame_len", bus.frame_len, 0);
        chk("rst_buf_data", bus.buf_data, 0);
        chk("rst_trig_auto", bus.trig_auto, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Rising single-shot on a ramp: fires on 151
        load_cfg(8'd150, 8'd100, 1'b0, 1'b1);
        pulse_start();
        chk("t1_armed", bus.state, 1);
        run_frame(1'b1, 0, first_data, n_wr, span, ready);
        chk("t1_ready", ready, 1);
        chk("t1_first_data", first_data, 151);
        chk("t1_n_wr", n_wr, LEN);
        chk("t1_span", span, LEN);
        chk("t1_frame_len", bus.frame_len, LEN);
        chk("t1_state_ready", bus.state, 4);
        chk("t1_trig_auto", bus.trig_auto, 0);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t1_ack_rd_en", bus.buf_rd_en, 0);
        chk("t1_ack_idle", bus.state, 0);

        // Hysteresis band holds, config ignored outside IDLE, then stop mid-capture
        pulse_start();
        drive_n(8'd50, 3);
        chk("t3_wait", bus.state, 2);
        load_cfg(8'd120, 8'd115, 1'b1, 1'b0);
        wr_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.adc_data = (i % 2 == 0) ? 8'd110 : 8'd140;
            tick();
            wr_seen |= bus.buf_wr;
        end
        chk("t3_no_fire", wr_seen, 0);
        chk("t3_still_wait", bus.state, 2);
        chk("t3_trig_auto", bus.trig_auto, 0);
        drive_n(8'd151, 1);
        chk("t3_fire_wr", bus.buf_wr, 1);
        chk("t3_fire_data", bus.buf_data, 151);
        chk("t3_fire_len0", bus.frame_len, 0);
        rd_seen = 1'b0;
        for (int i = 0; i < 600 && !(bus.buf_wr && bus.frame_len == 16'd499); i++) begin
            drive_n(8'd151, 1);
            rd_seen |= bus.buf_rd_en;
        end
        chk("t4_reach_500", bus.frame_len, 499);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t4_stop_wr", bus.buf_wr, 0);
        chk("t4_stop_idle", bus.state, 0);
        chk("t4_stop_len", bus.frame_len, 500);
        chk("t4_stop_rd_en", bus.buf_rd_en, 0);
        repeat (4) begin
            tick();
            rd_seen |= bus.buf_rd_en;
        end
        chk("t4_len_held", bus.frame_len, 500);
        chk("t4_rd_never", rd_seen, 0);

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t5_start_stop", bus.state, 0);

        // Falling edge, continuous mode, two frames
        load_cfg(8'd150, 8'd100, 1'b1, 1'b0);
        pulse_start();
        drive_n(8'd200, 3);
        chk("t6_wait", bus.state, 2);
        drive_n(8'd120, 5);
        chk("t6_band_wait", bus.state, 2);
        chk("t6_band_wr", bus.buf_wr, 0);
        run_frame(1'b0, 90, first_data, n_wr, span, ready);
        chk("t6_ready", ready, 1);
        chk("t6_first_data", first_data, 90);
        chk("t6_n_wr", n_wr, LEN);
        chk("t6_frame_len", bus.frame_len, LEN);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("t6_ack_arm", bus.state, 1);
        chk("t6_ack_rd_en", bus.buf_rd_en, 0);
        chk("t6_ack_len_clr", bus.frame_len, 0);
        drive_n(8'd90, 5);
        chk("t6_no_pre_arm", bus.state, 1);
        chk("t6_no_pre_wr", bus.buf_wr, 0);
        drive_n(8'd200, 3);
        chk("t6_wait2", bus.state, 2);
        run_frame(1'b0, 80, first_data, n_wr, span, ready);
        chk("t6_ready2", ready, 1);
        chk("t6_first_data2", first_data, 80);
        chk("t6_n_wr2", n_wr, LEN);
        chk("t6_frame_len2", bus.frame_len, LEN);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t6_stop_idle", bus.state, 0);

        // Asynchronous reset in the middle of a capture
        pulse_start();
        drive_n(8'd200, 3);
        drive_n(8'd80, 10);
        chk("t7_capturing", bus.buf_wr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_state", bus.state, 0);
        chk("t7_rst_wr", bus.buf_wr, 0);
        chk("t7_rst_len", bus.frame_len, 0);
        chk("t7_rst_data", bus.buf_data, 0);
        chk("t7_rst_rd_en", bus.buf_rd_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Default config is rising again: low samples lead to WAIT
        pulse_start();
        drive_n(8'd50, 3);
        chk("t7_default_rising", bus.state, 2);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
